disp_page_arbiter: RTL and testbench



---
 rtl/disp_page_arbiter_pkg.sv | 12 +
 rtl/disp_page_arbiter_step_tick_gen.sv | 19 +
 rtl/disp_page_arbiter.sv | 85 ++++++++
 tb/tb_disp_page_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/disp_page_arbiter_pkg.sv
// disp_page_arbiter_pkg: shared FSM state encoding and parameter defaults for the display page arbiter
package disp_page_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    SHOW     = 2'd2,
    FADE_OUT = 2'd3
  } state_t;
  localparam int DW_DEF            = 4;
  localparam int DWELL_CNT_DEF     = 50_000_000;
  localparam int FADE_STEP_CNT_DEF = 1_562_500;
endpackage

// File: rtl/disp_page_arbiter_step_tick_gen.sv
// step_tick_gen: mod-M counter (clk, reset, clr in; tick out) whose tick is high for the one cycle the count sits at M-1
module step_tick_gen
  import disp_page_arbiter_pkg::*;
#(
  parameter int M = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = M > 1 ? $clog2(M) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(M - 1);
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/disp_page_arbiter.sv
// disp_page_arbiter: round-robin display sharing with dwell and fades (clk, reset, req, page0/1 hex+dp, duty_max in; gnt, hex_out, dp_out, an_dt, busy out)
module disp_page_arbiter
  import disp_page_arbiter_pkg::*;
#(
  parameter int DWELL_CNT     = DWELL_CNT_DEF,
  parameter int FADE_STEP_CNT = FADE_STEP_CNT_DEF,
  parameter int DW            = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [15:0]   page0_hex,
  input  logic [3:0]    page0_dp,
  input  logic [15:0]   page1_hex,
  input  logic [3:0]    page1_dp,
  input  logic [DW-1:0] duty_max,
  output logic [1:0]    gnt,
  output logic [15:0]   hex_out,
  output logic [3:0]    dp_out,
  output logic [DW-1:0] an_dt,
  output logic          busy
);
  state_t state, state_n;
  logic [1:0] gnt_n;
  logic last, last_n;
  logic [DW-1:0] dt_n;
  logic step_tick, dwell_tick, cur_req, oth_req;
  assign cur_req = |(req & gnt);
  assign oth_req = |(req & ~gnt);
  step_tick_gen #(.M(FADE_STEP_CNT)) u_step (
    .clk(clk), .reset(reset), .clr(state == IDLE || state == SHOW), .tick(step_tick)
  );
  step_tick_gen #(.M(DWELL_CNT)) u_dwell (
    .clk(clk), .reset(reset), .clr(state != SHOW), .tick(dwell_tick)
  );
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    dt_n    = an_dt;
    case (state)
      IDLE: if (|req) begin
        state_n = FADE_IN;
        gnt_n   = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : (req[1] ? 2'b10 : 2'b01);
        dt_n    = '0;
      end
      FADE_IN: if (step_tick) begin
        dt_n    = an_dt >= duty_max ? duty_max : an_dt + DW'(1);
        state_n = an_dt >= duty_max ? SHOW : FADE_IN;
      end
      SHOW: begin
        dt_n = duty_max;
        if (!cur_req || (dwell_tick && oth_req)) state_n = FADE_OUT;
      end
      FADE_OUT: if (step_tick) begin
        if (an_dt != '0) dt_n = an_dt - DW'(1);
        else begin
          last_n  = gnt[1];
          state_n = (oth_req || cur_req) ? FADE_IN : IDLE;
          gnt_n   = oth_req ? ~gnt : (cur_req ? gnt : 2'b00);
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      last    <= 1'b1;
      an_dt   <= '0;
      hex_out <= '0;
      dp_out  <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      last    <= last_n;
      an_dt   <= dt_n;
      hex_out <= gnt_n[0] ? page0_hex : (gnt_n[1] ? page1_hex : '0);
      dp_out  <= gnt_n[0] ? page0_dp : (gnt_n[1] ? page1_dp : '0);
      busy    <= state_n == FADE_IN || state_n == FADE_OUT;
    end
  end
endmodule

// File: tb/tb_disp_page_arbiter.sv
// tb_disp_page_arbiter: randomized scoreboard bench for disp_page_arbiter against a phase/elapsed-time reference model
module tb_disp_page_arbiter;
  localparam int DWELL = 8;
  localparam int STEP  = 2;
  localparam int S_IDLE = 0, S_IN = 1, S_SHOW = 2, S_OUT = 3;
  logic clk = 0, reset = 1;
  logic [1:0] req = 0;
  logic [15:0] p0h = 0, p1h = 0;
  logic [3:0] p0d = 0, p1d = 0, duty = 4'hF;
  logic [1:0] gnt;
  logic [15:0] hex_out;
  logic [3:0] dp_out, an_dt;
  logic busy;
  bit rnd = 0;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [1:0] gnt;
    logic [15:0] hex;
    logic [3:0] dp;
    logic [3:0] dt;
    logic busy;
  } snap_t;
  snap_t q[$];
  int m_st = S_IDLE, m_dt = 0, m_el = 0;
  bit m_on = 0, m_pg = 0, m_last = 1;
  always #5 clk = ~clk;
  disp_page_arbiter #(.DWELL_CNT(DWELL), .FADE_STEP_CNT(STEP), .DW(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .page0_hex(p0h), .page0_dp(p0d), .page1_hex(p1h), .page1_dp(p1d),
    .duty_max(duty), .gnt(gnt), .hex_out(hex_out), .dp_out(dp_out),
    .an_dt(an_dt), .busy(busy)
  );
  always @(posedge clk) begin : model
    int nst;
    bit step, dw;
    snap_t e;
    if (reset) begin
      m_st = S_IDLE; m_on = 0; m_pg = 0; m_last = 1; m_dt = 0; m_el = 0;
    end else begin
      step = (m_st == S_IN || m_st == S_OUT) && (m_el % STEP == STEP - 1);
      dw = m_st == S_SHOW && (m_el % DWELL == DWELL - 1);
      nst = m_st;
      case (m_st)
        S_IDLE: if (req != 2'b00) begin
          m_on = 1;
          m_pg = (req == 2'b11) ? !m_last : req[1];
          m_dt = 0;
          nst = S_IN;
        end
        S_IN: if (step) begin
          if (m_dt >= int'(duty)) begin m_dt = int'(duty); nst = S_SHOW; end
          else m_dt++;
        end
        S_SHOW: begin
          m_dt = int'(duty);
          if (!req[m_pg] || (dw && req[!m_pg])) nst = S_OUT;
        end
        default: if (step) begin
          if (m_dt > 0) m_dt--;
          else begin
            m_last = m_pg;
            if (req[!m_pg]) begin m_pg = !m_pg; nst = S_IN; end
            else if (req[m_pg]) nst = S_IN;
            else begin m_on = 0; nst = S_IDLE; end
          end
        end
      endcase
      m_el = (nst == m_st) ? m_el + 1 : 0;
      m_st = nst;
    end
    e.gnt  = m_on ? (m_pg ? 2'b10 : 2'b01) : 2'b00;
    e.hex  = m_on ? (m_pg ? p1h : p0h) : 16'h0;
    e.dp   = m_on ? (m_pg ? p1d : p0d) : 4'h0;
    e.dt   = 4'(m_dt);
    e.busy = m_st == S_IN || m_st == S_OUT;
    q.push_back(e);
  end
  always @(negedge clk) begin : monitor
    snap_t e, a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {gnt, hex_out, dp_out, an_dt, busy};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs @%0t: got gnt=%b hex=%h dp=%h an_dt=%0d busy=%b, required gnt=%b hex=%h dp=%h an_dt=%0d busy=%b",
                 $time, a.gnt, a.hex, a.dp, a.dt, a.busy, e.gnt, e.hex, e.dp, e.dt, e.busy);
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd) begin
        p0h = 16'($urandom); p1h = 16'($urandom);
        p0d = 4'($urandom); p1d = 4'($urandom);
      end
    end
  endtask
  task automatic wait_st(int st, int dt, string tag);
    int i;
    for (i = 0; i < 300 && !(m_st == st && (dt < 0 || m_dt == dt)); i++) cyc(1);
    checks++;
    if (!(m_st == st && (dt < 0 || m_dt == dt))) begin
      failures++;
      $display("FAIL wait_%s: model state=%0d an_dt=%0d, required state=%0d an_dt=%0d", tag, m_st, m_dt, st, dt);
    end
  endtask
  task automatic pulse_reset();
    reset = 1;
    cyc(1);
    reset = 0;
  endtask
  initial begin
    p0h = 16'h1234; p0d = 4'h5; p1h = 16'hABCD; p1d = 4'hA;
    cyc(3);
    reset = 0;
    req = 2'b01;
    cyc(50);
    pulse_reset();
    req = 2'b11;
    cyc(200);
    req = 2'b01;
    pulse_reset();
    wait_st(S_SHOW, -1, "show_drop");
    cyc(3);
    req = 2'b00;
    wait_st(S_IDLE, 0, "idle_drop");
    req = 2'b01;
    wait_st(S_SHOW, -1, "show_duty");
    cyc(3);
    duty = 4'h5;
    cyc(5);
    req = 2'b00;
    wait_st(S_IDLE, 0, "idle_duty");
    duty = 4'h0;
    req = 2'b01;
    cyc(10);
    duty = 4'hF;
    cyc(40);
    req = 2'b11;
    pulse_reset();
    wait_st(S_OUT, 7, "fadeout7");
    pulse_reset();
    cyc(60);
    req = 2'b01;
    pulse_reset();
    cyc(150);
    rnd = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) req = 2'($urandom);
      if ($urandom_range(0, 99) == 0) duty = 4'($urandom);
      reset = $urandom_range(0, 399) == 0;
      cyc(1);
    end
    rnd = 0;
    reset = 0;
    cyc(2);
    checks++;
    if (checks < 1000) begin
      failures++;
      $display("FAIL check_count: got %0d comparisons, required at least 1000", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
